// File: rtl/qsp_iq_dispatch.sv
// qsp_iq_dispatch: IQ0 producer for the QSP core.
// Buffers host instruction words in a circular queue and presents one
// registered word per cycle to core decode, filling with NOP_INSN when
// nothing can be issued (empty queue, flush) and holding during stall.
module qsp_iq_dispatch #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] NOP_INSN  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic                       stall,
    input  logic                       flush,
    output logic [31:0]                instruction,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty,
    output logic                       full,
    output logic [CNT_WIDTH-1:0]       issued_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Status and handshake derived from the registered fill level
    always_comb begin
        empty    = (occupancy == '0);
        full     = (occupancy == OCC_W'(DEPTH));
        in_ready = !full && !flush;
        push     = in_valid && in_ready;
        pop      = !empty && !stall && !flush;
    end

    // Queue storage write; pointers decide what is live, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers and fill level; power-of-two DEPTH lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Registered issue stage: flush beats stall, stall holds, else pop or NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_INSN;
            issue_valid <= 1'b0;
            issued_cnt  <= '0;
        end else if (flush) begin
            instruction <= NOP_INSN;
            issue_valid <= 1'b0;
        end else if (stall) begin
            instruction <= instruction;
            issue_valid <= issue_valid;
        end else if (pop) begin
            instruction <= mem[rd_ptr];
            issue_valid <= 1'b1;
            issued_cnt  <= issued_cnt + CNT_WIDTH'(1);
        end else begin
            instruction <= NOP_INSN;
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qsp_iq_dispatch.sv
// Directed, table-driven bench for qsp_iq_dispatch.
module tb_qsp_iq_dispatch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        rst, in_valid, in_ready, stall, flush, issue_valid, empty, full;
    logic [31:0] in_instr, instruction;
    logic [3:0]  occupancy;
    logic [15:0] issued_cnt;

    qsp_iq_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .stall(stall), .flush(flush),
        .instruction(instruction), .issue_valid(issue_valid),
        .occupancy(occupancy), .empty(empty), .full(full),
        .issued_cnt(issued_cnt)
    );

    // Narrow-counter instance for the counter wrap case
    logic        w_rst, w_in_valid, w_in_ready, w_stall, w_flush, w_issue_valid, w_empty, w_full;
    logic [31:0] w_in_instr, w_instruction;
    logic [3:0]  w_occupancy;
    logic [3:0]  w_issued_cnt;

    qsp_iq_dispatch #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(w_rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(w_in_instr), .stall(w_stall), .flush(w_flush),
        .instruction(w_instruction), .issue_valid(w_issue_valid),
        .occupancy(w_occupancy), .empty(w_empty), .full(w_full),
        .issued_cnt(w_issued_cnt)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] din;
        logic        stl;
        logic        fl;
        logic [31:0] e_ins;
        logic        e_iv;
        logic [3:0]  e_occ;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_cnt;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                                input logic s, input logic f, input logic [31:0] ei,
                                input logic eiv, input logic [3:0] eo, input logic [15:0] ec);
        vec_t t;
        t.rst = r; t.vld = v; t.din = d; t.stl = s; t.fl = f;
        t.e_ins = ei; t.e_iv = eiv; t.e_occ = eo; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; stall = 1'b0; flush = 1'b0;
        w_rst = 1'b1; w_in_valid = 1'b0; w_in_instr = '0; w_stall = 1'b0; w_flush = 1'b0;

        // rst, vld, din, stall, flush | instr, iv, occ, cnt
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1111_0001, 0, 0, 32'h0,         0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h1111_0002, 0, 0, 32'h1111_0001, 1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h1111_0003, 0, 0, 32'h1111_0002, 1, 1, 2));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h1111_0003, 1, 0, 3));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3));
        tbl.push_back(mk(0, 1, 32'hAAAA_0001, 0, 0, 32'h0,         0, 1, 3));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'hAAAA_0001, 1, 0, 4));
        tbl.push_back(mk(0, 1, 32'hAAAA_0002, 1, 0, 32'hAAAA_0001, 1, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'hAAAA_0001, 1, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'hAAAA_0001, 1, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'hAAAA_0002, 1, 0, 5));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 5));
        tbl.push_back(mk(0, 1, 32'hB000_0000, 1, 0, 32'h0,         0, 1, 5));
        tbl.push_back(mk(0, 1, 32'hB000_0001, 1, 0, 32'h0,         0, 2, 5));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 1, 0, 32'h0,         0, 3, 5));
        tbl.push_back(mk(0, 1, 32'hB000_0003, 1, 0, 32'h0,         0, 4, 5));
        tbl.push_back(mk(0, 1, 32'hB000_0004, 1, 0, 32'h0,         0, 5, 5));
        tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0,         0, 0, 5));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 5));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_instr = tbl[i].din;
            stall = tbl[i].stl; flush = tbl[i].fl;
            step();
            chk($sformatf("v%0d.instruction", i), instruction, tbl[i].e_ins);
            chk($sformatf("v%0d.issue_valid", i), 32'(issue_valid), 32'(tbl[i].e_iv));
            chk($sformatf("v%0d.occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("v%0d.issued_cnt", i), 32'(issued_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tbl[i].e_occ == 4'd0));
        end
        exp_cnt = 5;

        // Fill to DEPTH under stall, reject the ninth word, then drain in order
        stall = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = 32'hC000_0000 + 32'(i);
            #0 chk($sformatf("fill%0d.in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("fill%0d.occupancy", i), 32'(occupancy), 32'(i + 1));
        end
        in_instr = 32'hC000_00FF;
        #0;
        chk("full.full", 32'(full), 32'd1);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("ninth.occupancy", 32'(occupancy), 32'd8);
        chk("ninth.issue_valid", 32'(issue_valid), 32'd0);
        stall = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_cnt++;
            chk($sformatf("drain%0d.instruction", i), instruction, 32'hC000_0000 + 32'(i));
            chk($sformatf("drain%0d.issue_valid", i), 32'(issue_valid), 32'd1);
            chk($sformatf("drain%0d.occupancy", i), 32'(occupancy), 32'(7 - i));
        end
        step();
        chk("drained.instruction", instruction, 32'h0);
        chk("drained.issue_valid", 32'(issue_valid), 32'd0);
        chk("drained.empty", 32'(empty), 32'd1);
        chk("drained.issued_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Steady push+pop at occupancy 1 across several pointer wraps
        in_valid = 1'b1; in_instr = 32'hD000_0000;
        step();
        chk("stream0.instruction", instruction, 32'h0);
        chk("stream0.occupancy", 32'(occupancy), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            in_instr = 32'hD000_0000 + 32'(i);
            step();
            exp_cnt++;
            chk($sformatf("stream%0d.instruction", i), instruction, 32'hD000_0000 + 32'(i - 1));
            chk($sformatf("stream%0d.occupancy", i), 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        step();
        exp_cnt++;
        chk("stream_end.instruction", instruction, 32'hD000_0014);
        chk("stream_end.occupancy", 32'(occupancy), 32'd0);
        chk("stream_end.issued_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Reset mid-stream beats a concurrent push and pending pop
        in_valid = 1'b1; in_instr = 32'hE000_0000;
        step();
        in_instr = 32'hE000_0001;
        step();
        chk("pre_rst.instruction", instruction, 32'hE000_0000);
        rst = 1'b1; in_instr = 32'hE000_0002;
        step();
        chk("rst.instruction", instruction, 32'h0);
        chk("rst.issue_valid", 32'(issue_valid), 32'd0);
        chk("rst.occupancy", 32'(occupancy), 32'd0);
        chk("rst.issued_cnt", 32'(issued_cnt), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #0 chk("post_rst.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("post_rst.instruction", instruction, 32'h0);
        chk("post_rst.occupancy", 32'(occupancy), 32'd0);

        // Counter wrap on the narrow instance: 16 issues wrap a 4-bit count
        step();
        w_rst = 1'b0; w_in_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            w_in_instr = 32'hF000_0000 + 32'(k);
            step();
        end
        chk("wrap.pre_cnt", 32'(w_issued_cnt), 32'hF);
        w_in_valid = 1'b0;
        step();
        chk("wrap.cnt", 32'(w_issued_cnt), 32'h0);
        chk("wrap.instruction", w_instruction, 32'hF000_0010);
        chk("wrap.issue_valid", 32'(w_issue_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
